// File: rtl/sdram_err_recovery.sv
`default_nettype none
// ============================================================================
// Module      : sdram_err_recovery
// Description : Recovery sequencer driven by the SDRAM watchdog's sticky error
//               flag. On error it blocks new commands and drains in-flight
//               traffic. It then requests PRECHARGE ALL and a re-init from the
//               controller, and pulses the watchdog's active-low reset.
//               Bounded retries with per-step timeouts; escalates to a latched
//               FATAL state that software must release.
//               Optional: define SDRAM_RECOV_CAUSE_LOG_EN to record the last
//               failure cause on last_cause (tied to 0 otherwise).
// Revision    : 1.0 - initial release
// ============================================================================
module sdram_err_recovery #(
    parameter int DRAIN_TIMEOUT = 1024,
    parameter int STEP_TIMEOUT  = 4096,
    parameter int MAX_RETRY     = 3,
    parameter int WD_RST_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       error_flag,
    input  logic       ctrl_idle,
    input  logic       pall_ack,
    input  logic       init_done,
    input  logic       clear_fatal,
    output logic       cmd_block,
    output logic       pall_req,
    output logic       init_req,
    output logic       wd_rst_n,
    output logic       recovering,
    output logic       fatal,
    output logic [3:0] retry_cnt,
    output logic [7:0] recov_cnt,
    output logic [2:0] last_cause
);

    localparam int c_MAX_TO = (DRAIN_TIMEOUT > STEP_TIMEOUT) ? DRAIN_TIMEOUT : STEP_TIMEOUT;
    localparam int c_CNT_W  = $clog2(c_MAX_TO) + 1;

    localparam logic [c_CNT_W-1:0] c_CNT_ONE    = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0] c_DRAIN_LAST = c_CNT_W'(DRAIN_TIMEOUT - 1);
    localparam logic [c_CNT_W-1:0] c_STEP_LAST  = c_CNT_W'(STEP_TIMEOUT - 1);
    localparam logic [c_CNT_W-1:0] c_WD_LAST    = c_CNT_W'(WD_RST_CYCLES);
    localparam logic [3:0]         c_MAX_RETRY  = 4'(MAX_RETRY);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_DRAIN  = 3'd1,
        S_PALL   = 3'd2,
        S_REINIT = 3'd3,
        S_RETRY  = 3'd4,
        S_CLEAR  = 3'd5,
        S_FATAL  = 3'd6
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_CNT_W-1:0] w_next_cnt;
    logic               w_counting;
    logic               w_idle_entry;

    // Next-state and step-counter decode; acks are tested before timeouts so an
    // ack arriving on the timeout cycle still advances the sequence.
    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = '0;
        w_counting   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (error_flag) w_next_state = S_DRAIN;
            end
            S_DRAIN: begin
                w_counting = 1'b1;
                if (ctrl_idle || (r_cnt == c_DRAIN_LAST)) w_next_state = S_PALL;
            end
            S_PALL: begin
                w_counting = 1'b1;
                if (pall_ack)                  w_next_state = S_REINIT;
                else if (r_cnt == c_STEP_LAST) w_next_state = S_RETRY;
            end
            S_REINIT: begin
                w_counting = 1'b1;
                if (init_done)                 w_next_state = S_CLEAR;
                else if (r_cnt == c_STEP_LAST) w_next_state = S_RETRY;
            end
            S_RETRY: begin
                // retry_cnt was already bumped on the way in
                if (retry_cnt == c_MAX_RETRY) w_next_state = S_FATAL;
                else                          w_next_state = S_PALL;
            end
            S_CLEAR: begin
                w_counting = 1'b1;
                if (r_cnt == c_WD_LAST) w_next_state = S_IDLE;
            end
            S_FATAL: begin
                if (clear_fatal) w_next_state = S_CLEAR;
            end
            default: w_next_state = S_IDLE;
        endcase

        if ((w_next_state == r_state) && w_counting) w_next_cnt = r_cnt + c_CNT_ONE;
    end

    assign w_idle_entry = (r_state == S_CLEAR) && (w_next_state == S_IDLE);

    // State, step counter and all outputs registered from the next-state decode
    // so every output changes on the same edge as the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            cmd_block  <= 1'b0;
            pall_req   <= 1'b0;
            init_req   <= 1'b0;
            wd_rst_n   <= 1'b1;
            recovering <= 1'b0;
            fatal      <= 1'b0;
            retry_cnt  <= 4'd0;
            recov_cnt  <= 8'd0;
        end else begin
            r_state    <= w_next_state;
            r_cnt      <= w_next_cnt;
            cmd_block  <= (w_next_state != S_IDLE);
            pall_req   <= (w_next_state == S_PALL);
            init_req   <= (w_next_state == S_REINIT);
            wd_rst_n   <= !((w_next_state == S_CLEAR) && (w_next_cnt < c_WD_LAST));
            recovering <= (w_next_state != S_IDLE) && (w_next_state != S_FATAL);
            fatal      <= (w_next_state == S_FATAL);
            if (w_next_state == S_RETRY) begin
                retry_cnt <= retry_cnt + 4'd1;
            end else if (w_idle_entry) begin
                retry_cnt <= 4'd0;
                if (recov_cnt != 8'hFF) recov_cnt <= recov_cnt + 8'd1;
            end
        end
    end

`ifdef SDRAM_RECOV_CAUSE_LOG_EN
    logic [2:0] r_last_cause;

    // Latch the most recent failure cause; a successful recovery leaves it alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_cause <= 3'd0;
        end else if ((r_state == S_DRAIN) && (w_next_state == S_PALL) && !ctrl_idle) begin
            r_last_cause <= 3'd1;
        end else if ((r_state == S_PALL) && (w_next_state == S_RETRY)) begin
            r_last_cause <= 3'd2;
        end else if ((r_state == S_REINIT) && (w_next_state == S_RETRY)) begin
            r_last_cause <= 3'd3;
        end else if ((r_state == S_RETRY) && (w_next_state == S_FATAL)) begin
            r_last_cause <= 3'd4;
        end
    end

    assign last_cause = r_last_cause;
`else
    assign last_cause = 3'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sdram_err_recovery.sv
`default_nettype none
// ============================================================================
// Module      : tb_sdram_err_recovery
// Description : Directed self-checking bench for sdram_err_recovery
//               (DRAIN_TIMEOUT=16, STEP_TIMEOUT=32, MAX_RETRY=3,
//               WD_RST_CYCLES=2).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sdram_err_recovery;

`ifdef SDRAM_RECOV_CAUSE_LOG_EN
    localparam bit c_CAUSE_EN = 1'b1;
`else
    localparam bit c_CAUSE_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       error_flag = 1'b0;
    logic       ctrl_idle = 1'b0;
    logic       pall_ack = 1'b0;
    logic       init_done = 1'b0;
    logic       clear_fatal = 1'b0;
    logic       cmd_block, pall_req, init_req, wd_rst_n, recovering, fatal;
    logic [3:0] retry_cnt;
    logic [7:0] recov_cnt;
    logic [2:0] last_cause;
    logic [20:0] st;

    int checks = 0;
    int errors = 0;

    sdram_err_recovery #(
        .DRAIN_TIMEOUT(16),
        .STEP_TIMEOUT (32),
        .MAX_RETRY    (3),
        .WD_RST_CYCLES(2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .error_flag (error_flag),
        .ctrl_idle  (ctrl_idle),
        .pall_ack   (pall_ack),
        .init_done  (init_done),
        .clear_fatal(clear_fatal),
        .cmd_block  (cmd_block),
        .pall_req   (pall_req),
        .init_req   (init_req),
        .wd_rst_n   (wd_rst_n),
        .recovering (recovering),
        .fatal      (fatal),
        .retry_cnt  (retry_cnt),
        .recov_cnt  (recov_cnt),
        .last_cause (last_cause)
    );

    // {cmd_block,pall_req,init_req,wd_rst_n,recovering,fatal,retry[3:0],recov[7:0],cause[2:0]}
    assign st = {cmd_block, pall_req, init_req, wd_rst_n, recovering, fatal,
                 retry_cnt, recov_cnt, last_cause};

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Stimulus only: from a PALL state, ack it, complete init, ride out CLEAR.
    task automatic finish_from_pall();
        pall_ack = 1'b1;
        tick();
        pall_ack  = 1'b0;
        init_done = 1'b1;
        tick();
        init_done = 1'b0;
        tick();
        tick();
        tick();
    endtask

    // Stimulus only: fastest possible clean episode (7 cycles).
    task automatic quick_episode();
        error_flag = 1'b1;
        tick();
        error_flag = 1'b0;
        ctrl_idle  = 1'b1;
        tick();
        ctrl_idle  = 1'b0;
        finish_from_pall();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        checks++;
        if (st !== 21'h020000) begin
            errors++;
            $display("FAIL reset_state: got %h want %h", st, 21'h020000);
        end
    endtask

    task automatic test_clean();
        int n;
        int low;
        error_flag = 1'b1;
        tick();
        error_flag = 1'b0;
        checks++;
        if ({cmd_block, recovering, pall_req} !== 3'b110) begin
            errors++;
            $display("FAIL clean_drain_entry: got %b want 110", {cmd_block, recovering, pall_req});
        end
        repeat (4) tick();
        checks++;
        if (pall_req !== 1'b0) begin
            errors++;
            $display("FAIL clean_drain_hold: pall_req got %b want 0", pall_req);
        end
        ctrl_idle = 1'b1;
        tick();
        ctrl_idle = 1'b0;
        checks++;
        if ({pall_req, init_req, cmd_block} !== 3'b101) begin
            errors++;
            $display("FAIL clean_pall_entry: got %b want 101", {pall_req, init_req, cmd_block});
        end
        tick();
        tick();
        pall_ack = 1'b1;
        tick();
        pall_ack = 1'b0;
        checks++;
        if ({pall_req, init_req} !== 2'b01) begin
            errors++;
            $display("FAIL clean_reinit_entry: got %b want 01", {pall_req, init_req});
        end
        repeat (9) tick();
        init_done = 1'b1;
        tick();
        init_done = 1'b0;
        checks++;
        if ({init_req, wd_rst_n, cmd_block} !== 3'b001) begin
            errors++;
            $display("FAIL clean_clear_entry: got %b want 001", {init_req, wd_rst_n, cmd_block});
        end
        low = 1;
        n   = 0;
        while (cmd_block && n < 10) begin
            tick();
            n++;
            if (!wd_rst_n) low++;
        end
        checks++;
        if (n !== 3 || low !== 2) begin
            errors++;
            $display("FAIL clean_clear_len: cycles got %0d want 3, wd low got %0d want 2", n, low);
        end
        checks++;
        if ({cmd_block, recovering, retry_cnt, recov_cnt} !== {2'b00, 4'd0, 8'd1}) begin
            errors++;
            $display("FAIL clean_idle: got blk=%b rec=%b retry=%0d recov=%0d want 0 0 0 1",
                     cmd_block, recovering, retry_cnt, recov_cnt);
        end
    endtask

    task automatic test_forced_drain();
        ctrl_idle  = 1'b0;
        error_flag = 1'b1;
        tick();
        error_flag = 1'b0;
        repeat (15) tick();
        checks++;
        if (pall_req !== 1'b0) begin
            errors++;
            $display("FAIL forced_early: pall_req got %b want 0 after 16 cycles", pall_req);
        end
        tick();
        checks++;
        if (pall_req !== 1'b1) begin
            errors++;
            $display("FAIL forced_pall: pall_req got %b want 1 on cycle 17", pall_req);
        end
        checks++;
        if (last_cause !== (c_CAUSE_EN ? 3'd1 : 3'd0)) begin
            errors++;
            $display("FAIL forced_cause: got %0d want %0d", last_cause, c_CAUSE_EN ? 1 : 0);
        end
        finish_from_pall();
        checks++;
        if ({cmd_block, recov_cnt, retry_cnt} !== {1'b0, 8'd2, 4'd0}) begin
            errors++;
            $display("FAIL forced_done: got blk=%b recov=%0d retry=%0d want 0 2 0",
                     cmd_block, recov_cnt, retry_cnt);
        end
    endtask

    task automatic test_single_retry();
        error_flag = 1'b1;
        tick();
        error_flag = 1'b0;
        ctrl_idle  = 1'b1;
        tick();
        ctrl_idle  = 1'b0;
        repeat (31) tick();
        checks++;
        if ({pall_req, retry_cnt} !== {1'b1, 4'd0}) begin
            errors++;
            $display("FAIL retry_pre_timeout: got pall=%b retry=%0d want 1 0", pall_req, retry_cnt);
        end
        tick();
        checks++;
        if ({pall_req, init_req, recovering, retry_cnt} !== {3'b001, 4'd1}) begin
            errors++;
            $display("FAIL retry_state: got pall=%b init=%b rec=%b retry=%0d want 0 0 1 1",
                     pall_req, init_req, recovering, retry_cnt);
        end
        tick();
        checks++;
        if ({pall_req, retry_cnt} !== {1'b1, 4'd1}) begin
            errors++;
            $display("FAIL retry_repall: got pall=%b retry=%0d want 1 1", pall_req, retry_cnt);
        end
        checks++;
        if (last_cause !== (c_CAUSE_EN ? 3'd2 : 3'd0)) begin
            errors++;
            $display("FAIL retry_cause: got %0d want %0d", last_cause, c_CAUSE_EN ? 2 : 0);
        end
        finish_from_pall();
        checks++;
        if ({cmd_block, retry_cnt, recov_cnt, last_cause} !==
            {1'b0, 4'd0, 8'd3, (c_CAUSE_EN ? 3'd2 : 3'd0)}) begin
            errors++;
            $display("FAIL retry_done: got blk=%b retry=%0d recov=%0d cause=%0d",
                     cmd_block, retry_cnt, recov_cnt, last_cause);
        end
    endtask

    task automatic test_ack_priority();
        error_flag = 1'b1;
        tick();
        error_flag = 1'b0;
        ctrl_idle  = 1'b1;
        tick();
        ctrl_idle  = 1'b0;
        repeat (31) tick();
        pall_ack = 1'b1;
        tick();
        pall_ack = 1'b0;
        checks++;
        if ({pall_req, init_req, retry_cnt} !== {2'b01, 4'd0}) begin
            errors++;
            $display("FAIL ack_priority: got pall=%b init=%b retry=%0d want 0 1 0",
                     pall_req, init_req, retry_cnt);
        end
        init_done = 1'b1;
        tick();
        init_done = 1'b0;
        repeat (3) tick();
        checks++;
        if (recov_cnt !== 8'd4) begin
            errors++;
            $display("FAIL ack_priority_done: recov got %0d want 4", recov_cnt);
        end
    endtask

    task automatic test_fatal();
        error_flag = 1'b1;
        tick();
        error_flag = 1'b0;
        ctrl_idle  = 1'b1;
        tick();
        ctrl_idle  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            pall_ack = 1'b1;
            tick();
            pall_ack = 1'b0;
            repeat (32) tick();
            checks++;
            if ({init_req, retry_cnt} !== {1'b0, 4'(i + 1)}) begin
                errors++;
                $display("FAIL fatal_retry%0d: got init=%b retry=%0d want 0 %0d",
                         i, init_req, retry_cnt, i + 1);
            end
            tick();
        end
        checks++;
        if ({fatal, cmd_block, recovering, pall_req, init_req, wd_rst_n} !== 6'b110001) begin
            errors++;
            $display("FAIL fatal_entry: got %b want 110001",
                     {fatal, cmd_block, recovering, pall_req, init_req, wd_rst_n});
        end
        checks++;
        if (last_cause !== (c_CAUSE_EN ? 3'd4 : 3'd0)) begin
            errors++;
            $display("FAIL fatal_cause: got %0d want %0d", last_cause, c_CAUSE_EN ? 4 : 0);
        end
        for (int i = 0; i < 6; i++) begin
            error_flag = i[0];
            tick();
        end
        error_flag = 1'b0;
        checks++;
        if ({fatal, cmd_block, recovering, pall_req} !== 4'b1100) begin
            errors++;
            $display("FAIL fatal_ignore_err: got %b want 1100", {fatal, cmd_block, recovering, pall_req});
        end
        clear_fatal = 1'b1;
        tick();
        clear_fatal = 1'b0;
        checks++;
        if ({fatal, wd_rst_n, cmd_block} !== 3'b001) begin
            errors++;
            $display("FAIL fatal_clear_entry: got %b want 001", {fatal, wd_rst_n, cmd_block});
        end
        repeat (3) tick();
        checks++;
        if ({fatal, cmd_block, wd_rst_n, retry_cnt, last_cause} !==
            {3'b001, 4'd0, (c_CAUSE_EN ? 3'd4 : 3'd0)}) begin
            errors++;
            $display("FAIL fatal_release: got fatal=%b blk=%b wd=%b retry=%0d cause=%0d",
                     fatal, cmd_block, wd_rst_n, retry_cnt, last_cause);
        end
    endtask

    task automatic test_reset_mid();
        error_flag = 1'b1;
        tick();
        error_flag = 1'b0;
        ctrl_idle  = 1'b1;
        tick();
        ctrl_idle  = 1'b0;
        pall_ack   = 1'b1;
        tick();
        pall_ack   = 1'b0;
        checks++;
        if (init_req !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_pre: init_req got %b want 1", init_req);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (st !== 21'h020000) begin
            errors++;
            $display("FAIL reset_mid: got %h want %h", st, 21'h020000);
        end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 255; i++) quick_episode();
        checks++;
        if (recov_cnt !== 8'd255) begin
            errors++;
            $display("FAIL sat_255: recov got %0d want 255", recov_cnt);
        end
        quick_episode();
        checks++;
        if ({recov_cnt, cmd_block, retry_cnt} !== {8'd255, 1'b0, 4'd0}) begin
            errors++;
            $display("FAIL sat_256: got recov=%0d blk=%b retry=%0d want 255 0 0",
                     recov_cnt, cmd_block, retry_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_clean();
        test_forced_drain();
        test_single_retry();
        test_ack_priority();
        test_fatal();
        test_reset_mid();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
